// File: rtl/sort_sequencer.sv
// sort_sequencer: control FSM for a 4-input word sorter.
// The words a..d sit in upstream registers and are read one at a time
// through a shared 4:1 mux. This block drives the mux select and watches
// the mux output. Each output word comes from one selection pass: a 4-cycle
// scan that finds the best unused entry, then an emit cycle on a
// valid/ready handshake. Ties keep the lowest index, so the order is stable.
module sort_sequencer #(
  parameter int WIDTH   = 16,
  parameter bit DESCEND = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [1:0]       mux_sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic [1:0]       out_rank,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [3:0]       used_q;
  logic [1:0]       rank_q;
  logic [WIDTH-1:0] best_q;
  logic [1:0]       best_idx_q;
  logic             have_best_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       idx_q;
  logic [1:0]       out_rank_q;
  logic             done_q;

  logic             better_d;
  logic             take_d;
  logic [WIDTH-1:0] best_d;
  logic [1:0]       best_idx_d;
  logic             accept_d;

  // Candidate evaluation for the entry currently on the mux. A candidate
  // replaces the running best only when it is strictly better, so an
  // earlier index wins any tie.
  always_comb begin
    better_d   = 1'b0;
    take_d     = 1'b0;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (DESCEND) begin
      better_d = (mux_y > best_q);
    end else begin
      better_d = (mux_y < best_q);
    end
    take_d = !used_q[sel_q] && (!have_best_q || better_d);
    if (take_d) begin
      best_d     = mux_y;
      best_idx_d = sel_q;
    end
  end

  assign accept_d = valid_q && out_ready;

  // Main sequencer: the scan passes, the output handshake and the done pulse.
  // All outputs come from registers in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      used_q      <= 4'b0000;
      rank_q      <= 2'd0;
      best_q      <= '0;
      best_idx_q  <= 2'd0;
      have_best_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      idx_q       <= 2'd0;
      out_rank_q  <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_q  <= 2'd0;
          done_q <= 1'b0;
          if (start) begin
            state_q     <= SCAN;
            used_q      <= 4'b0000;
            rank_q      <= 2'd0;
            have_best_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          if (take_d) begin
            have_best_q <= 1'b1;
          end
          if (sel_q == 2'd3) begin
            state_q    <= EMIT;
            valid_q    <= 1'b1;
            data_q     <= best_d;
            idx_q      <= best_idx_d;
            out_rank_q <= rank_q;
          end else begin
            sel_q <= sel_q + 2'd1;
          end
        end

        EMIT: begin
          if (accept_d) begin
            valid_q            <= 1'b0;
            used_q[best_idx_q] <= 1'b1;
            sel_q              <= 2'd0;
            if (rank_q == 2'd3) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= SCAN;
              rank_q      <= rank_q + 2'd1;
              have_best_q <= 1'b0;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign mux_sel   = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_rank  = out_rank_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: bench for sort_sequencer. It uses one descending and
// one ascending instance. Both read the same word registers through their own
// mux. Expected output order is derived from rank counting, not from a scan.
module tb_sort_sequencer;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] words [4];

  logic             start_dn, busy_dn, valid_dn, ready_dn, done_dn;
  logic [1:0]       sel_dn, idx_dn, rank_dn;
  logic [WIDTH-1:0] y_dn, data_dn;

  logic             start_up, busy_up, valid_up, ready_up, done_up;
  logic [1:0]       sel_up, idx_up, rank_up;
  logic [WIDTH-1:0] y_up, data_up;

  assign y_dn = words[sel_dn];
  assign y_up = words[sel_up];

  sort_sequencer #(.WIDTH(WIDTH), .DESCEND(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_dn), .busy(busy_dn),
    .mux_sel(sel_dn), .mux_y(y_dn), .out_valid(valid_dn), .out_ready(ready_dn),
    .out_data(data_dn), .out_idx(idx_dn), .out_rank(rank_dn), .done(done_dn)
  );

  sort_sequencer #(.WIDTH(WIDTH), .DESCEND(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n), .start(start_up), .busy(busy_up),
    .mux_sel(sel_up), .mux_y(y_up), .out_valid(valid_up), .out_ready(ready_up),
    .out_data(data_up), .out_idx(idx_up), .out_rank(rank_up), .done(done_up)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] got_data [4];
  int               got_idx  [4];
  int               got_rank [4];
  int               got_n;
  int               first_valid_cyc;
  int               done_cyc;
  int               unstable;
  bit               timed_out;
  int               exp_idx  [4];

  // Stable sort by counting: the position of word i equals the number of
  // words that beat it, plus the equal words that have a lower index.
  task automatic compute_expected(input bit desc);
    for (int i = 0; i < 4; i++) begin
      int pos;
      pos = 0;
      for (int j = 0; j < 4; j++) begin
        if (j != i) begin
          if (desc ? (words[j] > words[i]) : (words[j] < words[i])) pos++;
          else if (words[j] == words[i] && j < i) pos++;
        end
      end
      exp_idx[pos] = i;
    end
  endtask

  // Start one sort and collect the accepted words.
  // Cycle 1 is the cycle after the edge that samples start.
  // stall_rank and stall_len hold ready low when that rank is first offered.
  // A spurious start can be pulsed in cycle busy_start_cyc.
  task automatic run_sort(input bit asc, input int stall_rank, input int stall_len,
                          input int busy_start_cyc);
    int cyc, stall_left;
    bit holding;
    logic v, dn;
    logic [WIDTH-1:0] d, h_data;
    logic [1:0] ix, rk, h_idx, h_rank;
    got_n = 0; first_valid_cyc = -1; done_cyc = -1; unstable = 0; timed_out = 0;
    stall_left = stall_len; holding = 0;
    h_data = '0; h_idx = 2'd0; h_rank = 2'd0;
    @(negedge clk);
    if (asc) begin start_up = 1'b1; ready_up = 1'b1; end
    else begin start_dn = 1'b1; ready_dn = 1'b1; end
    @(negedge clk);
    cyc = 1;
    while (done_cyc < 0 && cyc < 200) begin
      v  = asc ? valid_up : valid_dn;
      d  = asc ? data_up  : data_dn;
      ix = asc ? idx_up   : idx_dn;
      rk = asc ? rank_up  : rank_dn;
      dn = asc ? done_up  : done_dn;
      if (asc) start_up = (cyc == busy_start_cyc);
      else     start_dn = (cyc == busy_start_cyc);
      if (dn) done_cyc = cyc;
      if (v) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (int'(rk) == stall_rank && stall_left > 0) begin
          if (!holding) begin
            h_data = d; h_idx = ix; h_rank = rk;
          end else if (d !== h_data || ix !== h_idx || rk !== h_rank) begin
            unstable++;
          end
          holding = 1;
          stall_left--;
          if (asc) ready_up = 1'b0; else ready_dn = 1'b0;
        end else begin
          if (holding && (d !== h_data || ix !== h_idx || rk !== h_rank)) unstable++;
          holding = 0;
          if (asc) ready_up = 1'b1; else ready_dn = 1'b1;
          if (got_n < 4) begin
            got_data[got_n] = d;
            got_idx[got_n]  = int'(ix);
            got_rank[got_n] = int'(rk);
          end
          got_n++;
        end
      end else begin
        if (asc) ready_up = 1'b1; else ready_dn = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start_up = 1'b0; start_dn = 1'b0; ready_up = 1'b1; ready_dn = 1'b1;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_dn, sel_dn, valid_dn, data_dn, idx_dn, rank_dn, done_dn} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dn got busy=%b sel=%0d valid=%b data=%h idx=%0d rank=%0d done=%b want all zero",
               busy_dn, sel_dn, valid_dn, data_dn, idx_dn, rank_dn, done_dn);
    end
    checks++;
    if ({busy_up, sel_up, valid_up, data_up, idx_up, rank_up, done_up} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_up got busy=%b sel=%0d valid=%b data=%h want all zero",
               busy_up, sel_up, valid_up, data_up);
    end
  endtask

  task automatic test_basic();
    int exp_d [4] = '{9, 7, 5, 1};
    int exp_i [4] = '{1, 3, 0, 2};
    words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd1; words[3] = 16'd7;
    run_sort(1'b0, -1, 0, -1);
    checks++;
    if (timed_out || got_n !== 4) begin
      errors++; $display("[TB] FAIL basic_count got %0d words timeout=%b want 4", got_n, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (int'(got_data[k]) !== exp_d[k] || got_idx[k] !== exp_i[k] || got_rank[k] !== k) begin
        errors++;
        $display("[TB] FAIL basic_word%0d got data=%0d idx=%0d rank=%0d want data=%0d idx=%0d rank=%0d",
                 k, got_data[k], got_idx[k], got_rank[k], exp_d[k], exp_i[k], k);
      end
    end
    checks++;
    if (first_valid_cyc !== 5 || done_cyc !== 21) begin
      errors++;
      $display("[TB] FAIL basic_latency got first_valid=%0d done=%0d want 5 and 21", first_valid_cyc, done_cyc);
    end
  endtask

  task automatic test_ties();
    for (int k = 0; k < 4; k++) words[k] = 16'h1234;
    run_sort(1'b0, -1, 0, -1);
    checks++;
    if (timed_out || got_n !== 4) begin
      errors++; $display("[TB] FAIL ties_count got %0d timeout=%b want 4", got_n, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_data[k] !== 16'h1234 || got_idx[k] !== k) begin
        errors++;
        $display("[TB] FAIL ties_word%0d got data=%h idx=%0d want data=1234 idx=%0d", k, got_data[k], got_idx[k], k);
      end
    end
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] exp_d [4];
    exp_d[0] = 16'hFFFF; exp_d[1] = 16'h8000; exp_d[2] = 16'h7FFF; exp_d[3] = 16'h0000;
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h8000; words[3] = 16'h7FFF;
    run_sort(1'b0, -1, 0, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (timed_out || got_data[k] !== exp_d[k]) begin
        errors++;
        $display("[TB] FAIL extremes_word%0d got %h want %h", k, got_data[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_ascending();
    int exp_d [4] = '{1, 5, 7, 9};
    int exp_i [4] = '{2, 0, 3, 1};
    words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd1; words[3] = 16'd7;
    run_sort(1'b1, -1, 0, -1);
    checks++;
    if (timed_out || done_cyc !== 21) begin
      errors++; $display("[TB] FAIL asc_done got cycle %0d want 21", done_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (int'(got_data[k]) !== exp_d[k] || got_idx[k] !== exp_i[k]) begin
        errors++;
        $display("[TB] FAIL asc_word%0d got data=%0d idx=%0d want data=%0d idx=%0d",
                 k, got_data[k], got_idx[k], exp_d[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_stall();
    words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd1; words[3] = 16'd7;
    run_sort(1'b0, 1, 3, -1);
    checks++;
    if (unstable !== 0) begin
      errors++; $display("[TB] FAIL stall_hold got %0d unstable samples want 0", unstable);
    end
    checks++;
    if (timed_out || done_cyc !== 24) begin
      errors++; $display("[TB] FAIL stall_done got cycle %0d want 24", done_cyc);
    end
    checks++;
    if (int'(got_data[1]) !== 7 || got_idx[1] !== 3 || int'(got_data[2]) !== 5) begin
      errors++;
      $display("[TB] FAIL stall_words got w1=%0d idx1=%0d w2=%0d want 7 3 5", got_data[1], got_idx[1], got_data[2]);
    end
  endtask

  task automatic test_busy_start();
    words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd1; words[3] = 16'd7;
    run_sort(1'b0, -1, 0, 7);
    checks++;
    if (timed_out || done_cyc !== 21 || int'(got_data[1]) !== 7 || got_idx[3] !== 2) begin
      errors++;
      $display("[TB] FAIL busy_start got done=%0d w1=%0d idx3=%0d want 21 7 2", done_cyc, got_data[1], got_idx[3]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy_dn !== 1'b0 || valid_dn !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_start_idle got busy=%b valid=%b want 0 0", busy_dn, valid_dn);
    end
  endtask

  task automatic test_reset_mid_sort();
    words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd1; words[3] = 16'd7;
    @(negedge clk); start_dn = 1'b1; ready_dn = 1'b1;
    @(negedge clk); start_dn = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (busy_dn !== 1'b1 || sel_dn !== 2'd1) begin
      errors++; $display("[TB] FAIL mid_sort_busy got busy=%b sel=%0d want 1 1", busy_dn, sel_dn);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_dn, sel_dn, valid_dn, data_dn, idx_dn, rank_dn, done_dn} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got busy=%b sel=%0d valid=%b data=%h idx=%0d rank=%0d done=%b want all zero",
               busy_dn, sel_dn, valid_dn, data_dn, idx_dn, rank_dn, done_dn);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_dn !== 1'b0 || valid_dn !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_no_resume got busy=%b valid=%b want 0 0", busy_dn, valid_dn);
    end
    run_sort(1'b0, -1, 0, -1);
    checks++;
    if (timed_out || done_cyc !== 21 || int'(got_data[0]) !== 9 || int'(got_data[3]) !== 1 ||
        got_idx[1] !== 3 || got_idx[2] !== 0) begin
      errors++;
      $display("[TB] FAIL mid_rerun got done=%0d w0=%0d w3=%0d idx1=%0d idx2=%0d want 21 9 1 3 0",
               done_cyc, got_data[0], got_data[3], got_idx[1], got_idx[2]);
    end
  endtask

  task automatic test_random(input bit asc, input int iters);
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < 4; k++) begin
        if (it % 2 == 1) words[k] = 16'($urandom_range(0, 3));
        else             words[k] = 16'($urandom);
      end
      compute_expected(!asc);
      run_sort(asc, -1, 0, -1);
      checks++;
      if (timed_out || got_n !== 4 || done_cyc !== 21) begin
        errors++;
        $display("[TB] FAIL random_run%0d got n=%0d done=%0d timeout=%b want 4 21 0", it, got_n, done_cyc, timed_out);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_idx[k] !== exp_idx[k] || got_data[k] !== words[exp_idx[k]] || got_rank[k] !== k) begin
          errors++;
          $display("[TB] FAIL random_run%0d_word%0d asc=%b got data=%h idx=%0d rank=%0d want data=%h idx=%0d rank=%0d",
                   it, k, asc, got_data[k], got_idx[k], got_rank[k], words[exp_idx[k]], exp_idx[k], k);
        end
      end
    end
  endtask

  // Test sequence; every test starts and ends with both instances idle.
  initial begin
    rst_n = 1'b0;
    start_dn = 1'b0; start_up = 1'b0; ready_dn = 1'b1; ready_up = 1'b1;
    for (int k = 0; k < 4; k++) words[k] = '0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_basic();
    test_ties();
    test_extremes();
    test_ascending();
    test_stall();
    test_busy_start();
    test_reset_mid_sort();
    test_random(1'b0, 8);
    test_random(1'b1, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
